// File: rtl/sha_nonce_scheduler_pkg.sv
// Shared widths and FSM state encodings for the SHA nonce scheduler.
package sha_nonce_scheduler_pkg;

    localparam int NONCE_W = 32;
    localparam int HDR_W   = 512;
    localparam int HASH_W  = 256;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE  = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

endpackage

// File: rtl/sha_target_cmp.sv
// Registered 256-bit unsigned hash < target compare; result is ready one cycle after en.
module sha_target_cmp
    import sha_nonce_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic [HASH_W-1:0] hash,
    input  logic [HASH_W-1:0] target,
    output logic              lt_p1
);

    // stage p0 -> p1: compare registered alongside the captured hash
    always_ff @(posedge clk) begin
        if (en) begin
            lt_p1 <= (hash < target);
        end
    end

endmodule

// File: rtl/sha_nonce_scheduler.sv
// Job latch, nonce sweep and hit reporting around the SHA miner core.
// Define SHA_SCHED_TIMEOUT_EN to re-issue a nonce when the miner stays silent for TIMEOUT_CYCLES.
module sha_nonce_scheduler
    import sha_nonce_scheduler_pkg::*;
#(
    parameter int NONCE_LSB      = 384,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               hdr_valid,
    output logic               hdr_ready,
    input  logic [HDR_W-1:0]   hdr_in,
    input  logic [NONCE_W-1:0] nonce_start,
    input  logic [NONCE_W-1:0] nonce_end,
    input  logic [HASH_W-1:0]  target,
    input  logic               abort,
    output logic               miner_valid,
    output logic [HDR_W-1:0]   miner_header,
    input  logic               miner_done,
    input  logic [HASH_W-1:0]  miner_hash,
    output logic               found_valid,
    input  logic               found_ready,
    output logic [NONCE_W-1:0] found_nonce,
    output logic [HASH_W-1:0]  found_hash,
    output logic               busy,
    output logic               done_pulse,
    output logic               timeout_err
);

    logic [2:0]         state;
    logic [NONCE_W-1:0] cur_nonce;
    logic [NONCE_W-1:0] nxt_nonce;
    logic [NONCE_W-1:0] end_nonce;
    logic [HASH_W-1:0]  target_q;
    logic [HASH_W-1:0]  hash_p1;
    logic [HDR_W-1:0]   hdr_job;
    logic               hit_p1;
    logic               cmp_en;
    logic               accept;
    logic               wait_expired;

    assign hdr_ready   = (state == ST_IDLE) && !abort;
    assign accept      = hdr_valid && hdr_ready;
    assign miner_valid = (state == ST_ISSUE);
    assign found_valid = (state == ST_REPORT);
    assign busy        = (state != ST_IDLE);
    assign done_pulse  = (state == ST_DONE);
    assign cmp_en      = (state == ST_WAIT) && miner_done && !abort;
    assign nxt_nonce   = cur_nonce + NONCE_W'(1);

    always_comb begin
        hdr_job = hdr_in;
        hdr_job[NONCE_LSB +: NONCE_W] = nonce_start;
    end

    sha_target_cmp u_cmp (
        .clk    (clk),
        .en     (cmp_en),
        .hash   (miner_hash),
        .target (target_q),
        .lt_p1  (hit_p1)
    );

    // stage p0 -> p1: job parameters and the hash under test
    always_ff @(posedge clk) begin
        if (accept) begin
            end_nonce <= nonce_end;
            target_q  <= target;
        end
        if (cmp_en) begin
            hash_p1 <= miner_hash;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cur_nonce    <= '0;
            miner_header <= '0;
            found_nonce  <= '0;
            found_hash   <= '0;
        end else if (abort) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cur_nonce    <= nonce_start;
                        miner_header <= hdr_job;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (miner_done) begin
                        state <= ST_CHECK;
                    end else if (wait_expired) begin
                        state <= ST_ISSUE;
                    end
                end
                ST_CHECK, ST_REPORT: begin
                    if (state == ST_CHECK && hit_p1) begin
                        found_nonce <= cur_nonce;
                        found_hash  <= hash_p1;
                        state       <= ST_REPORT;
                    end else if (state == ST_CHECK || found_ready) begin
                        // nonce_end is inclusive, so test before incrementing
                        if (cur_nonce == end_nonce) begin
                            state <= ST_DONE;
                        end else begin
                            cur_nonce <= nxt_nonce;
                            miner_header[NONCE_LSB +: NONCE_W] <= nxt_nonce;
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef SHA_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] wait_cnt;

    assign wait_expired = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= (state == ST_WAIT) && !abort && !miner_done && wait_expired;
            if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
        end
    end
`else
    assign wait_expired = 1'b0;
    assign timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// Directed bench for sha_nonce_scheduler with a fixed-latency miner model.
`timescale 1ns/1ps
module tb_sha_nonce_scheduler;

    localparam logic [255:0] TGT = {32'h0000_0000, 32'h00FF_FFFF, 192'h0};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         hdr_valid = 1'b0;
    logic         hdr_ready;
    logic [511:0] hdr_in = '0;
    logic [31:0]  nonce_start = '0;
    logic [31:0]  nonce_end = '0;
    logic [255:0] target = '0;
    logic         abort = 1'b0;
    logic         miner_valid;
    logic [511:0] miner_header;
    logic         miner_done = 1'b0;
    logic [255:0] miner_hash = '0;
    logic         found_valid;
    logic         found_ready = 1'b1;
    logic [31:0]  found_nonce;
    logic [255:0] found_hash;
    logic         busy;
    logic         done_pulse;
    logic         timeout_err;

    always #5 clk = ~clk;

    sha_nonce_scheduler #(.NONCE_LSB(384), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_in(hdr_in),
        .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target), .abort(abort),
        .miner_valid(miner_valid), .miner_header(miner_header), .miner_done(miner_done),
        .miner_hash(miner_hash), .found_valid(found_valid), .found_ready(found_ready),
        .found_nonce(found_nonce), .found_hash(found_hash), .busy(busy),
        .done_pulse(done_pulse), .timeout_err(timeout_err)
    );

    // miner configuration (written by the stimulus thread only)
    int           lat = 3;
    logic         miner_en = 1'b1;
    logic         sp_en = 1'b0;
    logic [31:0]  sp_nonce = '0;
    logic [255:0] sp_hash = '0;
    logic [255:0] nm_hash = '1;

    // miner model and event logs (written by the model only)
    int           cyc = 0;
    int           pend_cnt = 0;
    logic [31:0]  pend_nonce = '0;
    int           done_cyc = 0;
    logic         have_done = 1'b0;
    int           done_cnt = 0;
    int           to_cnt = 0;
    logic [31:0]  iss_nonce[$];
    logic [511:0] iss_hdr[$];
    int           gap_q[$];
    logic [31:0]  hit_nonce[$];
    logic [255:0] hit_hash[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        miner_done = 1'b0;
        if (pend_cnt > 0) begin
            pend_cnt = pend_cnt - 1;
            if (pend_cnt == 0 && miner_en) begin
                miner_done = 1'b1;
                miner_hash = (sp_en && pend_nonce == sp_nonce) ? sp_hash : nm_hash;
                done_cyc   = cyc;
                have_done  = 1'b1;
            end
        end
        if (miner_valid) begin
            pend_nonce = miner_header[384 +: 32];
            pend_cnt   = lat;
            iss_nonce.push_back(pend_nonce);
            iss_hdr.push_back(miner_header);
            gap_q.push_back(have_done ? cyc - done_cyc : 9999);
        end
        if (found_valid && found_ready) begin
            hit_nonce.push_back(found_nonce);
            hit_hash.push_back(found_hash);
        end
        if (done_pulse) done_cnt = done_cnt + 1;
        if (timeout_err) to_cnt = to_cnt + 1;
    end

    int nvec = 0;
    int nerr = 0;
    logic [511:0] tmpl;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start_job(input logic [31:0] s, input logic [31:0] e);
        int k = 0;
        while (!hdr_ready && k < 100) begin
            tick();
            k++;
        end
        check("hdr_ready_before_job", hdr_ready, 1);
        hdr_valid   = 1'b1;
        hdr_in      = tmpl;
        nonce_start = s;
        nonce_end   = e;
        target      = TGT;
        tick();
        hdr_valid = 1'b0;
        hdr_in    = '1;
        target    = '0;
    endtask

    task automatic wait_done(input string name, input int base, input int limit);
        int k = 0;
        while (done_cnt == base && k < limit) begin
            tick();
            k++;
        end
        if (done_cnt == base) check(name, done_cnt - base, 1);
    endtask

    task automatic wait_issues(input string name, input int cnt, input int limit);
        int k = 0;
        while (iss_nonce.size() < cnt && k < limit) begin
            tick();
            k++;
        end
        if (iss_nonce.size() < cnt) check(name, iss_nonce.size(), cnt);
    endtask

    typedef struct {
        logic [31:0]  s;
        logic [31:0]  e;
        logic         sp_en;
        logic [31:0]  spn;
        logic [255:0] sph;
        logic [255:0] nmh;
        int           reqs;
        int           hits;
        logic [31:0]  hitn;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int ib, hb, db, tb, mg;
        logic [31:0]  en;
        logic [511:0] eh;

        for (int i = 0; i < 16; i++) tmpl[i*32 +: 32] = 32'hC0DE_0000 + 32'h0101_0101 * i;

        tbl[0] = '{32'd5,          32'd7,          1'b0, 32'd0,  '0,         TGT + 256'd1, 3, 0, 32'd0};
        tbl[1] = '{32'hFFFF_FFFE, 32'd1,          1'b0, 32'd0,  '0,         TGT + 256'd1, 4, 0, 32'd0};
        tbl[2] = '{32'd9,          32'd9,          1'b1, 32'd9,  TGT,        TGT + 256'd1, 1, 0, 32'd0};
        tbl[3] = '{32'd10,         32'd12,         1'b1, 32'd11, '0,         '1,           3, 1, 32'd11};
        tbl[4] = '{32'd20,         32'd20,         1'b1, 32'd20, TGT - 256'd1, '1,         1, 1, 32'd20};
        tbl[5] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 32'd0,  '0,         {1'b1, 255'd0}, 2, 0, 32'd0};

        // reset values
        tick(3);
        check("rst_hdr_ready", hdr_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_miner_valid", miner_valid, 0);
        check("rst_found_valid", found_valid, 0);
        check("rst_done_pulse", done_pulse, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_miner_header", miner_header, 0);
        check("rst_found_nonce", found_nonce, 0);
        check("rst_found_hash", found_hash, 0);
        rst = 1'b0;
        tick(2);

        // table-driven sweeps, consumer always ready
        for (int v = 0; v < 6; v++) begin
            sp_en = tbl[v].sp_en; sp_nonce = tbl[v].spn; sp_hash = tbl[v].sph; nm_hash = tbl[v].nmh;
            ib = iss_nonce.size(); hb = hit_nonce.size(); db = done_cnt;
            start_job(tbl[v].s, tbl[v].e);
            wait_done($sformatf("v%0d_done_wait", v), db, 500);
            tick(3);
            check($sformatf("v%0d_reqs", v), iss_nonce.size() - ib, tbl[v].reqs);
            for (int i = 0; i < tbl[v].reqs && ib + i < iss_nonce.size(); i++) begin
                en = tbl[v].s + i;
                eh = tmpl;
                eh[384 +: 32] = en;
                check($sformatf("v%0d_nonce%0d", v, i), iss_nonce[ib+i], en);
                check($sformatf("v%0d_hdr%0d", v, i), iss_hdr[ib+i], eh);
            end
            check($sformatf("v%0d_hits", v), hit_nonce.size() - hb, tbl[v].hits);
            if (tbl[v].hits > 0 && hit_nonce.size() > hb) begin
                check($sformatf("v%0d_hit_nonce", v), hit_nonce[hb], tbl[v].hitn);
                check($sformatf("v%0d_hit_hash", v), hit_hash[hb], tbl[v].sph);
            end
            check($sformatf("v%0d_done_cnt", v), done_cnt - db, 1);
            check($sformatf("v%0d_busy_after", v), busy, 0);
            if (tbl[v].reqs > 1) begin
                mg = 9999;
                for (int i = ib + 1; i < gap_q.size(); i++) if (gap_q[i] < mg) mg = gap_q[i];
                check($sformatf("v%0d_min_gap", v), mg, 2);
            end
        end

        // hit held while consumer stalls
        sp_en = 1'b1; sp_nonce = 32'd2; sp_hash = TGT - 256'd5; nm_hash = TGT + 256'd1;
        ib = iss_nonce.size(); hb = hit_nonce.size(); db = done_cnt;
        found_ready = 1'b0;
        start_job(32'd0, 32'd3);
        begin
            int k = 0;
            while (!found_valid && k < 200) begin tick(); k++; end
        end
        check("stall_found_valid", found_valid, 1);
        check("stall_found_nonce", found_nonce, 32'd2);
        check("stall_found_hash", found_hash, TGT - 256'd5);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("stall_hold%0d_valid", i), found_valid, 1);
            check($sformatf("stall_hold%0d_nonce", i), found_nonce, 32'd2);
        end
        check("stall_no_new_issue", iss_nonce.size() - ib, 3);
        found_ready = 1'b1;
        tick();
        check("stall_release_valid", found_valid, 0);
        check("stall_release_issue", miner_valid, 1);
        wait_done("stall_done_wait", db, 200);
        tick(2);
        check("stall_reqs", iss_nonce.size() - ib, 4);
        if (iss_nonce.size() == ib + 4) check("stall_last_nonce", iss_nonce[ib+3], 32'd3);
        check("stall_hits", hit_nonce.size() - hb, 1);
        check("stall_done_cnt", done_cnt - db, 1);

        // abort in WAIT, miner answers late
        sp_en = 1'b0; lat = 10;
        ib = iss_nonce.size(); hb = hit_nonce.size(); db = done_cnt;
        start_job(32'd100, 32'd105);
        wait_issues("abort_issue_wait", ib + 1, 50);
        tick(2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_hdr_ready", hdr_ready, 1);
        check("abort_miner_valid", miner_valid, 0);
        tick(15);
        check("abort_late_reqs", iss_nonce.size() - ib, 1);
        check("abort_late_hits", hit_nonce.size() - hb, 0);
        check("abort_late_done", done_cnt - db, 0);
        check("abort_late_busy", busy, 0);

        // abort beats a simultaneous job offer
        abort = 1'b1; hdr_valid = 1'b1; hdr_in = tmpl;
        #1;
        check("abort_vs_hdr_ready", hdr_ready, 0);
        tick();
        abort = 1'b0; hdr_valid = 1'b0;
        tick(2);
        check("abort_vs_hdr_busy", busy, 0);
        check("abort_vs_hdr_reqs", iss_nonce.size() - ib, 1);

        // next job after abort starts from its own nonce_start
        lat = 3;
        ib = iss_nonce.size(); db = done_cnt;
        start_job(32'd200, 32'd201);
        wait_done("post_abort_done_wait", db, 200);
        tick(2);
        check("post_abort_reqs", iss_nonce.size() - ib, 2);
        if (iss_nonce.size() > ib) check("post_abort_first", iss_nonce[ib], 32'd200);

        // reset mid-job with a hit pending in the miner
        sp_en = 1'b1; sp_nonce = 32'd300; sp_hash = '0; lat = 5;
        hb = hit_nonce.size(); db = done_cnt; ib = iss_nonce.size();
        start_job(32'd300, 32'd310);
        wait_issues("rst_mid_issue_wait", ib + 1, 50);
        tick(2);
        rst = 1'b1;
        tick();
        check("rst_mid_busy", busy, 0);
        check("rst_mid_hdr_ready", hdr_ready, 1);
        check("rst_mid_found_valid", found_valid, 0);
        check("rst_mid_miner_header", miner_header, 0);
        check("rst_mid_found_nonce", found_nonce, 0);
        check("rst_mid_found_hash", found_hash, 0);
        rst = 1'b0;
        tick(10);
        check("rst_mid_hits", hit_nonce.size() - hb, 0);
        check("rst_mid_done", done_cnt - db, 0);
        check("rst_mid_busy_after", busy, 0);

        // silent miner
        sp_en = 1'b0; miner_en = 1'b0; lat = 3;
        ib = iss_nonce.size(); tb = to_cnt;
        start_job(32'd50, 32'd50);
        wait_issues("silent_issue_wait", ib + 1, 50);
        tick(20);
`ifdef SHA_SCHED_TIMEOUT_EN
        check("silent_reqs", iss_nonce.size() - ib, 2);
        if (iss_nonce.size() == ib + 2) begin
            check("silent_reissue_nonce", iss_nonce[ib+1], 32'd50);
            check("silent_reissue_gap", gap_q[ib+1] - gap_q[ib], 17);
        end
        check("silent_timeouts", to_cnt - tb, 1);
`else
        check("silent_reqs", iss_nonce.size() - ib, 1);
        check("silent_timeouts", to_cnt - tb, 0);
        check("silent_busy", busy, 1);
`endif
        abort = 1'b1;
        tick();
        abort = 1'b0;
        miner_en = 1'b1;
        tick(5);
        check("silent_abort_busy", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
